banked_rms: RTL and testbench
=============================

BANKED_RMS -- requirements
Module: banked_rms

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter NREG, default 64, register count; ADDR_W = clog2(NREG).
REQ-003 Parameter NFRAME, default 15, frame registers at addresses 0..NFRAME-1.
REQ-004 Parameter DEPTH, default 4, number of saved frames held on chip.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-006 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses.
- rd_data_a, rd_data_b  out  DATA_W  read data.
- wr_en1, wr_en2  in  1  write enables.
- wr_addr1, wr_addr2  in  ADDR_W  write addresses.
- wr_data1, wr_data2  in  DATA_W  write data.
- save_req, restore_req  in  1  frame push / pop request.
- flag_clr  in  1  clears sticky flags.
- busy, done  out  1  transfer in progress / one-cycle completion pulse.
- ovf, unf  out  1  sticky overflow / underflow.
- depth_cnt  out  clog2(DEPTH+1)  frames currently stored.
- io_in  in  DATA_W  external input, visible at address IO_IN = NFRAME.
- io_out  out  DATA_W  contents of register IO_OUT = NFRAME+1.
- cmp_mode  in  2  0 eq, 1 ne, 2 signed lt, 3 signed ge.
- cmp_result  out  1  comparison of rd_data_a against rd_data_b.

Function
REQ-007 Reads SHALL be combinational; address IO_IN returns io_in, every other address returns the stored register.
REQ-008 Writes SHALL commit at posedge clk; on equal addresses port 2 wins; writes to IO_IN are dropped.
REQ-009 A read of an address written in the same cycle SHALL return the old value (no bypass).
REQ-010 io_out SHALL equal register IO_OUT at all times (registered, updates the cycle after the write).
REQ-011 cmp_result SHALL be combinational per cmp_mode; lt/ge treat operands as two's complement DATA_W.
REQ-012 FSM states SHALL be IDLE, SAVE, RESTORE, DONE.
REQ-013 In IDLE or DONE, save_req with depth_cnt<DEPTH SHALL enter SAVE; with depth_cnt==DEPTH, ovf SHALL set and the state is unchanged.
REQ-014 In IDLE or DONE, restore_req with depth_cnt>0 SHALL enter RESTORE; with depth_cnt==0, unf SHALL set and the state is unchanged.
REQ-015 save_req and restore_req in the same cycle: save SHALL take priority, restore is discarded.
REQ-016 Requests arriving in SAVE or RESTORE SHALL be ignored without setting flags.
REQ-017 SAVE SHALL copy register i into stack slot [depth_cnt][i], one register per cycle, i=0..NFRAME-1, NFRAME cycles, then increment depth_cnt.
REQ-018 RESTORE SHALL copy stack slot [depth_cnt-1][i] into register i, one per cycle, NFRAME cycles, then decrement depth_cnt.
REQ-019 busy SHALL be high exactly NFRAME cycles, starting the cycle after request acceptance; DONE SHALL follow for one cycle with done=1 and busy=0.
REQ-020 While busy, external writes to addresses 0..NFRAME-1 SHALL be dropped; writes to other addresses proceed.
REQ-021 During RESTORE, register reads of frame addresses SHALL return the current partially restored contents.
REQ-022 flag_clr SHALL clear ovf and unf; a set and a clear in the same cycle SHALL leave the flag set.

Reset
REQ-023 rst_n low SHALL immediately force: all registers 0, io_out 0, state IDLE, busy 0, done 0, depth_cnt 0, ovf 0, unf 0, including in mid-transfer.
REQ-024 Stack contents SHALL NOT be reset; they are unreachable while depth_cnt is 0.

Structure
REQ-025 Package rms_pkg SHALL hold the FSM state enum, cmp_mode codes, and default parameter constants.
REQ-026 The stack memory with its slot indexing SHALL be sub-module rms_frame_stack (one write port, one read port, DEPTH x NFRAME x DATA_W).

Verification
REQ-027 Reset then write reg k = k for k=1..63 via port 2 -> reads return k; address 15 returns io_in=0xA5A5; io_out=16.
REQ-028 Same-cycle writes to addr 20, port1 0x1111, port2 0x2222 -> reg20=0x2222; write to addr 15 -> read still returns io_in.
REQ-029 Fill frame 0..14 with 100+i, save, overwrite with 0, restore -> busy 15 cycles per transfer, done pulse, regs 100+i, depth 1->0.
REQ-030 Five saves with DEPTH=4 -> ovf=1 on the fifth, depth_cnt=4; restore at depth 0 -> unf=1; flag_clr -> both 0.
REQ-031 Port-1 write to addr 3 during SAVE -> dropped; write to addr 40 during SAVE -> committed.
REQ-032 a=0xFFFF, b=0x0001 -> cmp_mode 2 gives 1, mode 3 gives 0, mode 0 gives 0, mode 1 gives 1; rst_n low mid-RESTORE -> busy 0, depth_cnt 0, regs 0.

Source files
------------

// File: rtl/rms_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rms_pkg
// Description : Shared types and constants for the banked register file with
//               an on-chip frame save/restore stack.
// Revision    : 1.0 - initial release
// ============================================================================
package rms_pkg;

    // Frame transfer controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } rms_state_t;

    // Comparator mode codes
    localparam logic [1:0] c_CMP_EQ = 2'd0;
    localparam logic [1:0] c_CMP_NE = 2'd1;
    localparam logic [1:0] c_CMP_LT = 2'd2;
    localparam logic [1:0] c_CMP_GE = 2'd3;

    // Default geometry
    localparam int c_DEF_DATA_W = 16;
    localparam int c_DEF_NREG   = 64;
    localparam int c_DEF_NFRAME = 15;
    localparam int c_DEF_DEPTH  = 4;

endpackage
`default_nettype wire

// File: rtl/rms_frame_stack.sv
`default_nettype none
// ============================================================================
// Module      : rms_frame_stack
// Description : DEPTH x NFRAME x DATA_W frame storage, one synchronous write
//               port and one combinational read port, addressed by
//               (slot, register index). Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rms_frame_stack
    import rms_pkg::*;
#(
    parameter int  DATA_W = c_DEF_DATA_W,
    parameter int  NFRAME = c_DEF_NFRAME,
    parameter int  DEPTH  = c_DEF_DEPTH,
    localparam int SLOT_W = (DEPTH  > 1) ? $clog2(DEPTH)  : 1,
    localparam int IDX_W  = (NFRAME > 1) ? $clog2(NFRAME) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    localparam int c_ENTRIES = DEPTH * NFRAME;
    localparam int c_MEM_AW  = (c_ENTRIES > 1) ? $clog2(c_ENTRIES) : 1;

    logic [DATA_W-1:0]   r_mem [c_ENTRIES];
    logic [c_MEM_AW-1:0] w_waddr;
    logic [c_MEM_AW-1:0] w_raddr;

    // Slots are laid out back to back, NFRAME entries each
    assign w_waddr = c_MEM_AW'(wr_slot) * c_MEM_AW'(NFRAME) + c_MEM_AW'(wr_idx);
    assign w_raddr = c_MEM_AW'(rd_slot) * c_MEM_AW'(NFRAME) + c_MEM_AW'(rd_idx);

    assign rd_data = r_mem[w_raddr];

    // Single write port, no reset on the storage array
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[w_waddr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/banked_rms.sv
`default_nettype none
// ============================================================================
// Module      : banked_rms
// Description : NREG x DATA_W register file with two combinational read
//               ports, two write ports, a memory-mapped input/output pair,
//               an operand comparator and a frame save/restore engine that
//               pushes/pops registers 0..NFRAME-1 to an on-chip stack.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_rms
    import rms_pkg::*;
#(
    parameter int  DATA_W  = c_DEF_DATA_W,
    parameter int  NREG    = c_DEF_NREG,
    parameter int  NFRAME  = c_DEF_NFRAME,
    parameter int  DEPTH   = c_DEF_DEPTH,
    localparam int ADDR_W  = $clog2(NREG),
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  rd_addr_a,
    input  logic [ADDR_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0]  rd_data_a,
    output logic [DATA_W-1:0]  rd_data_b,
    input  logic               wr_en1,
    input  logic               wr_en2,
    input  logic [ADDR_W-1:0]  wr_addr1,
    input  logic [ADDR_W-1:0]  wr_addr2,
    input  logic [DATA_W-1:0]  wr_data1,
    input  logic [DATA_W-1:0]  wr_data2,
    input  logic               save_req,
    input  logic               restore_req,
    input  logic               flag_clr,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic               unf,
    output logic [DEPTH_W-1:0] depth_cnt,
    input  logic [DATA_W-1:0]  io_in,
    output logic [DATA_W-1:0]  io_out,
    input  logic [1:0]         cmp_mode,
    output logic               cmp_result
);

    localparam int SLOT_W = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
    localparam int IDX_W  = (NFRAME > 1) ? $clog2(NFRAME) : 1;
    localparam int IO_OUT = NFRAME + 1;
    localparam logic [ADDR_W-1:0] c_IO_IN = ADDR_W'(NFRAME);

    rms_state_t          r_state;
    rms_state_t          w_next;
    logic [IDX_W-1:0]    r_idx;
    logic [DEPTH_W-1:0]  r_depth;
    logic                r_ovf;
    logic                r_unf;
    logic [DATA_W-1:0]   r_regs [NREG];

    logic                w_last;
    logic                w_ovf_set;
    logic                w_unf_set;
    logic                w_wr1_ok;
    logic                w_wr2_ok;
    logic [DATA_W-1:0]   w_stack_rd;
    logic [SLOT_W-1:0]   w_push_slot;
    logic [SLOT_W-1:0]   w_pop_slot;

    assign w_last = (r_idx == IDX_W'(NFRAME - 1));

    // Frame registers are owned by the transfer engine while busy; the
    // IO_IN address has no writable storage behind it
    assign w_wr1_ok = wr_en1 && (wr_addr1 != c_IO_IN) && !(busy && (wr_addr1 < c_IO_IN));
    assign w_wr2_ok = wr_en2 && (wr_addr2 != c_IO_IN) && !(busy && (wr_addr2 < c_IO_IN));

    // Combinational read ports with IO_IN overlay
    assign rd_data_a = (rd_addr_a == c_IO_IN) ? io_in : r_regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == c_IO_IN) ? io_in : r_regs[rd_addr_b];

    assign io_out    = r_regs[IO_OUT];
    assign depth_cnt = r_depth;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

    // Push targets the first free slot, pop reads the top occupied slot
    assign w_push_slot = SLOT_W'(r_depth);
    assign w_pop_slot  = SLOT_W'(r_depth - DEPTH_W'(1));

    rms_frame_stack #(
        .DATA_W (DATA_W),
        .NFRAME (NFRAME),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk     (clk),
        .wr_en   (r_state == ST_SAVE),
        .wr_slot (w_push_slot),
        .wr_idx  (r_idx),
        .wr_data (r_regs[ADDR_W'(r_idx)]),
        .rd_slot (w_pop_slot),
        .rd_idx  (r_idx),
        .rd_data (w_stack_rd)
    );

    // Operand comparator, lt/ge on two's-complement values
    always_comb begin
        cmp_result = 1'b0;
        case (cmp_mode)
            c_CMP_EQ: cmp_result = (rd_data_a == rd_data_b);
            c_CMP_NE: cmp_result = (rd_data_a != rd_data_b);
            c_CMP_LT: cmp_result = ($signed(rd_data_a) <  $signed(rd_data_b));
            c_CMP_GE: cmp_result = ($signed(rd_data_a) >= $signed(rd_data_b));
            default:  cmp_result = 1'b0;
        endcase
    end

    // Transfer FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, request acceptance (save wins over restore) and status
    always_comb begin
        w_next    = r_state;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                done   = (r_state == ST_DONE);
                w_next = ST_IDLE;
                if (save_req) begin
                    if (r_depth < DEPTH_W'(DEPTH)) begin
                        w_next = ST_SAVE;
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                end else if (restore_req) begin
                    if (r_depth != '0) begin
                        w_next = ST_RESTORE;
                    end else begin
                        w_unf_set = 1'b1;
                    end
                end
            end
            ST_SAVE, ST_RESTORE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Register index walk and stack depth bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_depth <= '0;
        end else begin
            if (busy && !w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_idx <= '0;
            end
            if (busy && w_last) begin
                if (r_state == ST_SAVE) begin
                    r_depth <= r_depth + DEPTH_W'(1);
                end else begin
                    r_depth <= r_depth - DEPTH_W'(1);
                end
            end
        end
    end

    // Sticky flags: a new set beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~flag_clr);
            r_unf <= w_unf_set | (r_unf & ~flag_clr);
        end
    end

    // Register file: port 2 overrides port 1, restore owns frame regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr1_ok) begin
                r_regs[wr_addr1] <= wr_data1;
            end
            if (w_wr2_ok) begin
                r_regs[wr_addr2] <= wr_data2;
            end
            if (r_state == ST_RESTORE) begin
                r_regs[ADDR_W'(r_idx)] <= w_stack_rd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_banked_rms.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_rms
// Description : Directed, table-driven bench for banked_rms.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_rms;

    localparam int DATA_W = 16;
    localparam int NREG   = 64;
    localparam int NFRAME = 15;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic [15:0] rd_data_a, rd_data_b;
    logic        wr_en1 = 1'b0, wr_en2 = 1'b0;
    logic [5:0]  wr_addr1 = '0, wr_addr2 = '0;
    logic [15:0] wr_data1 = '0, wr_data2 = '0;
    logic        save_req = 1'b0, restore_req = 1'b0, flag_clr = 1'b0;
    logic        busy, done, ovf, unf;
    logic [2:0]  depth_cnt;
    logic [15:0] io_in = 16'hA5A5;
    logic [15:0] io_out;
    logic [1:0]  cmp_mode = '0;
    logic        cmp_result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic [1:0]  mode;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ec;
    } vec_t;

    vec_t vt [12];

    banked_rms #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .NFRAME (NFRAME),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .wr_en1      (wr_en1),
        .wr_en2      (wr_en2),
        .wr_addr1    (wr_addr1),
        .wr_addr2    (wr_addr2),
        .wr_data1    (wr_data1),
        .wr_data2    (wr_data2),
        .save_req    (save_req),
        .restore_req (restore_req),
        .flag_clr    (flag_clr),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf),
        .unf         (unf),
        .depth_cnt   (depth_cnt),
        .io_in       (io_in),
        .io_out      (io_out),
        .cmp_mode    (cmp_mode),
        .cmp_result  (cmp_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr2(input logic [5:0] a, input logic [15:0] d);
        wr_en2   = 1'b1;
        wr_addr2 = a;
        wr_data2 = d;
        step();
        wr_en2   = 1'b0;
    endtask

    // Issue one request and follow the transfer until busy drops
    task automatic xfer(input bit is_save, input bit inject, input bit partial, output int cycles);
        if (is_save) save_req = 1'b1;
        else         restore_req = 1'b1;
        step();
        save_req    = 1'b0;
        restore_req = 1'b0;
        cycles = 0;
        while (busy && cycles < 40) begin
            if (inject && cycles == 0) begin
                wr_en1 = 1'b1; wr_addr1 = 6'd3;  wr_data1 = 16'hDEAD;
                wr_en2 = 1'b1; wr_addr2 = 6'd40; wr_data2 = 16'hBEEF;
            end else begin
                wr_en1 = 1'b0;
                wr_en2 = 1'b0;
            end
            if (partial && cycles == 3) begin
                rd_addr_a = 6'd0;
                rd_addr_b = 6'd14;
                #1;
                chk("partial_reg0", rd_data_a, 32'd100);
                chk("partial_reg14", rd_data_b, 32'd0);
            end
            cycles++;
            step();
        end
        wr_en1 = 1'b0;
        wr_en2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int n;

        vt[0]  = '{6'd1,  6'd2,  2'd0, 16'd1,    16'd2,    1'b0};
        vt[1]  = '{6'd63, 6'd62, 2'd1, 16'd63,   16'd62,   1'b1};
        vt[2]  = '{6'd15, 6'd16, 2'd0, 16'hA5A5, 16'd16,   1'b0};
        vt[3]  = '{6'd50, 6'd51, 2'd2, 16'hFFFF, 16'h0001, 1'b1};
        vt[4]  = '{6'd50, 6'd51, 2'd3, 16'hFFFF, 16'h0001, 1'b0};
        vt[5]  = '{6'd50, 6'd51, 2'd0, 16'hFFFF, 16'h0001, 1'b0};
        vt[6]  = '{6'd50, 6'd51, 2'd1, 16'hFFFF, 16'h0001, 1'b1};
        vt[7]  = '{6'd7,  6'd7,  2'd0, 16'd7,    16'd7,    1'b1};
        vt[8]  = '{6'd7,  6'd7,  2'd3, 16'd7,    16'd7,    1'b1};
        vt[9]  = '{6'd51, 6'd50, 2'd2, 16'h0001, 16'hFFFF, 1'b0};
        vt[10] = '{6'd0,  6'd40, 2'd2, 16'd0,    16'd40,   1'b1};
        vt[11] = '{6'd16, 6'd15, 2'd3, 16'd16,   16'hA5A5, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rd_addr_a = 6'd5;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_depth", depth_cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);
        chk("rst_io_out", io_out, 0);
        chk("rst_reg5", rd_data_a, 0);
        rst_n = 1'b1;
        step();

        // Load reg k = k, then operands for the signed compare
        for (int k = 1; k < 64; k++) wr2(6'(k), 16'(k));
        chk("io_out_16", io_out, 32'd16);
        wr2(6'd50, 16'hFFFF);
        wr2(6'd51, 16'h0001);

        for (int i = 0; i < 12; i++) begin
            rd_addr_a = vt[i].a;
            rd_addr_b = vt[i].b;
            cmp_mode  = vt[i].mode;
            #1;
            chk($sformatf("vec%0d_rd_a", i), rd_data_a, vt[i].ea);
            chk($sformatf("vec%0d_rd_b", i), rd_data_b, vt[i].eb);
            chk($sformatf("vec%0d_cmp", i), cmp_result, vt[i].ec);
        end

        // Same-cycle dual write: old value visible before the edge, port 2 wins after
        rd_addr_a = 6'd20;
        wr_en1 = 1'b1; wr_addr1 = 6'd20; wr_data1 = 16'h1111;
        wr_en2 = 1'b1; wr_addr2 = 6'd20; wr_data2 = 16'h2222;
        #1;
        chk("no_bypass", rd_data_a, 32'd20);
        step();
        wr_en1 = 1'b0;
        wr_en2 = 1'b0;
        #1;
        chk("port2_wins", rd_data_a, 32'h2222);
        wr_en1 = 1'b1; wr_addr1 = 6'd15; wr_data1 = 16'h7777;
        step();
        wr_en1 = 1'b0;
        rd_addr_a = 6'd15;
        #1;
        chk("io_in_write_dropped", rd_data_a, 32'hA5A5);

        // Save a frame while writes hit frame and non-frame addresses
        for (int i = 0; i < NFRAME; i++) wr2(6'(i), 16'(100 + i));
        xfer(1'b1, 1'b1, 1'b0, cyc);
        chk("save_busy_cycles", cyc, 32'd15);
        chk("save_done", done, 1);
        chk("save_depth", depth_cnt, 1);
        step();
        chk("done_one_cycle", done, 0);
        rd_addr_a = 6'd3;
        rd_addr_b = 6'd40;
        #1;
        chk("busy_frame_write_dropped", rd_data_a, 32'd103);
        chk("busy_other_write_kept", rd_data_b, 32'hBEEF);

        // Clobber and restore
        for (int i = 0; i < NFRAME; i++) wr2(6'(i), 16'd0);
        rd_addr_a = 6'd5;
        #1;
        chk("clobbered_reg5", rd_data_a, 0);
        xfer(1'b0, 1'b0, 1'b1, cyc);
        chk("restore_busy_cycles", cyc, 32'd15);
        chk("restore_done", done, 1);
        chk("restore_depth", depth_cnt, 0);
        for (int i = 0; i < NFRAME; i++) begin
            rd_addr_a = 6'(i);
            #1;
            chk($sformatf("restored_reg%0d", i), rd_data_a, 32'(100 + i));
        end
        step();

        // Fill the stack, then overflow
        for (int s = 0; s < DEPTH; s++) xfer(1'b1, 1'b0, 1'b0, cyc);
        chk("full_depth", depth_cnt, 32'd4);
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        chk("ovf_set", ovf, 1);
        chk("ovf_no_start", busy, 0);
        chk("ovf_depth", depth_cnt, 32'd4);

        // Drain, then underflow
        for (int s = 0; s < DEPTH; s++) xfer(1'b0, 1'b0, 1'b0, cyc);
        chk("drained_depth", depth_cnt, 0);
        chk("ovf_sticky", ovf, 1);
        restore_req = 1'b1;
        step();
        restore_req = 1'b0;
        chk("unf_set", unf, 1);
        chk("unf_no_start", busy, 0);

        // Set and clear together keeps the flag; clear alone drops it
        restore_req = 1'b1;
        flag_clr    = 1'b1;
        step();
        restore_req = 1'b0;
        chk("set_beats_clr_unf", unf, 1);
        chk("clr_ovf", ovf, 0);
        step();
        flag_clr = 1'b0;
        chk("clr_unf", unf, 0);
        chk("clr_ovf_hold", ovf, 0);

        // Simultaneous requests: save wins, no underflow
        save_req    = 1'b1;
        restore_req = 1'b1;
        step();
        save_req    = 1'b0;
        restore_req = 1'b0;
        chk("prio_save_busy", busy, 1);
        chk("prio_no_unf", unf, 0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        chk("prio_depth", depth_cnt, 1);

        // Asynchronous reset in the middle of a restore
        restore_req = 1'b1;
        step();
        restore_req = 1'b0;
        repeat (5) step();
        chk("mid_restore_busy", busy, 1);
        rd_addr_a = 6'd0;
        rd_addr_b = 6'd40;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_depth", depth_cnt, 0);
        chk("arst_reg0", rd_data_a, 0);
        chk("arst_reg40", rd_data_b, 0);
        chk("arst_io_out", io_out, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_arst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
